// File: rtl/button_event_decoder.sv
// Classifies debounced button presses as short/long/double and drives effect index and bypass.
// Optional double-press detection is enabled by defining DOUBLE_CLICK_EN.
module button_event_decoder #(
  parameter int unsigned c_long_limit  = 10_000_000,
  parameter int unsigned c_double_gap  = 3_000_000,
  parameter int unsigned c_num_effects = 4,
  parameter int unsigned EFFECT_W      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_switch,
  output logic                o_short,
  output logic                o_long,
  output logic                o_double,
  output logic [EFFECT_W-1:0] o_effect,
  output logic                o_bypass
);

  if (c_long_limit < 2 || c_long_limit > 32'hFF_FFFF ||
      c_double_gap < 2 || c_double_gap > 32'hFF_FFFF ||
      c_num_effects < 2 || c_num_effects > (32'd1 << EFFECT_W)) begin : g_param_check
    $error("button_event_decoder: parameter out of range");
  end

`ifdef DOUBLE_CLICK_EN
  typedef enum logic [2:0] {S_IDLE, S_PRESS1, S_WAIT_GAP, S_PRESS2, S_HOLD} state_e;
  localparam logic [23:0] GAP_LAST = 24'(c_double_gap - 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_PRESS1, S_HOLD} state_e;
`endif

  localparam logic [23:0]         LONG_LAST = 24'(c_long_limit - 1);
  localparam logic [EFFECT_W-1:0] EFF_LAST  = EFFECT_W'(c_num_effects - 1);

  state_e              state, state_next;
  logic [23:0]         r_count, count_next;
  logic                r_prev;
  logic                press;
  logic                short_next, long_next;
  logic [EFFECT_W-1:0] effect_next;
  logic                bypass_next;
`ifdef DOUBLE_CLICK_EN
  logic                double_next;
`endif

  assign press = i_switch & ~r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      r_count  <= '0;
      r_prev   <= 1'b1;
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_effect <= '0;
      o_bypass <= 1'b0;
    end else begin
      state    <= state_next;
      r_count  <= count_next;
      r_prev   <= i_switch;
      o_short  <= short_next;
      o_long   <= long_next;
      o_effect <= effect_next;
      o_bypass <= bypass_next;
    end
  end

`ifdef DOUBLE_CLICK_EN
  always_ff @(posedge clk) begin
    if (rst) o_double <= 1'b0;
    else     o_double <= double_next;
  end
`else
  assign o_double = 1'b0;
`endif

  always_comb begin
    state_next = state;
    count_next = r_count;
    case (state)
      S_IDLE: begin
        if (press) begin
          state_next = S_PRESS1;
          count_next = '0;
        end
      end
      S_PRESS1: begin
        if (i_switch) begin
          if (r_count == LONG_LAST) state_next = S_HOLD;
          else                      count_next = r_count + 24'd1;
        end else begin
`ifdef DOUBLE_CLICK_EN
          state_next = S_WAIT_GAP;
          count_next = '0;
`else
          state_next = S_IDLE;
`endif
        end
      end
`ifdef DOUBLE_CLICK_EN
      // A press on the final gap cycle takes priority over the short timeout.
      S_WAIT_GAP: begin
        if (press)                    state_next = S_PRESS2;
        else if (r_count == GAP_LAST) state_next = S_IDLE;
        else                          count_next = r_count + 24'd1;
      end
      S_PRESS2: begin
        if (!i_switch) state_next = S_IDLE;
      end
`endif
      S_HOLD: begin
        if (!i_switch) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    short_next  = 1'b0;
    long_next   = 1'b0;
`ifdef DOUBLE_CLICK_EN
    double_next = 1'b0;
`endif
    effect_next = o_effect;
    bypass_next = o_bypass;
    case (state)
      S_PRESS1: begin
        if (i_switch && r_count == LONG_LAST) long_next = 1'b1;
`ifndef DOUBLE_CLICK_EN
        if (!i_switch) short_next = 1'b1;
`endif
      end
`ifdef DOUBLE_CLICK_EN
      S_WAIT_GAP: begin
        if (!press && r_count == GAP_LAST) short_next = 1'b1;
      end
      S_PRESS2: begin
        if (!i_switch) double_next = 1'b1;
      end
`endif
      default: ;
    endcase

    if (short_next) begin
      effect_next = (o_effect == EFF_LAST) ? '0 : o_effect + EFFECT_W'(1);
    end
`ifdef DOUBLE_CLICK_EN
    if (double_next) begin
      effect_next = (o_effect == '0) ? EFF_LAST : o_effect - EFFECT_W'(1);
    end
`endif
    if (long_next) bypass_next = ~o_bypass;
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Table-driven bench for button_event_decoder with a queue scoreboard of expected pulses.
// Expectations follow DOUBLE_CLICK_EN so the bench serves both builds.
module tb_button_event_decoder;
  localparam int unsigned L = 20;
  localparam int unsigned G = 10;
  localparam int unsigned N = 3;
  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_switch = 1'b0;
  logic         o_short, o_long, o_double, o_bypass;
  logic [W-1:0] o_effect;

  always #5 clk = ~clk;

  button_event_decoder #(
    .c_long_limit (L),
    .c_double_gap (G),
    .c_num_effects(N),
    .EFFECT_W     (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_switch(i_switch),
    .o_short (o_short),
    .o_long  (o_long),
    .o_double(o_double),
    .o_effect(o_effect),
    .o_bypass(o_bypass)
  );

  typedef enum int {EV_NONE, EV_SHORT, EV_LONG, EV_DOUBLE} ev_e;
  typedef struct {
    int           at;
    ev_e          kind;
    logic [W-1:0] eff;
    logic         byp;
  } exp_t;
  typedef struct {
    int  p1;
    int  gap;
    int  p2;
    ev_e ev1;
    ev_e ev2;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[11];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_eff = '0;
  logic         model_byp = 1'b0;
  logic [W-1:0] seen_eff = '0;
  logic         seen_byp = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    int   npulse;
    ev_e  got;
    exp_t ex;
    #1;
    if (rst) begin
      seen_eff = '0;
      seen_byp = 1'b0;
    end
    npulse = int'(o_short === 1'b1) + int'(o_long === 1'b1) + int'(o_double === 1'b1);
    if (npulse > 0) begin
      checks++;
      got = (o_short === 1'b1) ? EV_SHORT : (o_long === 1'b1) ? EV_LONG : EV_DOUBLE;
      if (npulse > 1) begin
        errors++;
        $display("FAIL multi_pulse: got %0d simultaneous pulses at edge %0d, expected 1", npulse, cyc);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d at edge %0d, expected no pulse", int'(got), cyc);
      end else begin
        ex = sb.pop_front();
        if (got != ex.kind || cyc != ex.at) begin
          errors++;
          $display("FAIL pulse: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                   int'(got), cyc, int'(ex.kind), ex.at);
        end
        seen_eff = ex.eff;
        seen_byp = ex.byp;
      end
    end
    checks++;
    if (o_effect !== seen_eff || o_bypass !== seen_byp) begin
      errors++;
      $display("FAIL outputs at edge %0d: got effect %0d bypass %0b, expected effect %0d bypass %0b",
               cyc, o_effect, o_bypass, seen_eff, seen_byp);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push_ev(input int at, input ev_e k);
    case (k)
      EV_SHORT:  model_eff = (model_eff == W'(N - 1)) ? '0 : model_eff + W'(1);
      EV_DOUBLE: model_eff = (model_eff == '0) ? W'(N - 1) : model_eff - W'(1);
      EV_LONG:   model_byp = ~model_byp;
      default: ;
    endcase
    if (k != EV_NONE) sb.push_back('{at: at, kind: k, eff: model_eff, byp: model_byp});
  endtask

  task automatic drive(input logic lvl, input int n);
    i_switch = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int budget = 60;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  // Called at a falling edge; edge numbers are counted from the next rising edge.
  task automatic run_vec(input vec_t v);
    int k1, r1, k2;
    k1 = cyc + 1;
    r1 = k1 + v.p1;
    k2 = r1 + v.gap;
    case (v.ev1)
      EV_LONG:   push_ev(k1 + L, EV_LONG);
`ifdef DOUBLE_CLICK_EN
      EV_SHORT:  push_ev(r1 + G, EV_SHORT);
`else
      EV_SHORT:  push_ev(r1, EV_SHORT);
`endif
      EV_DOUBLE: push_ev(k2 + v.p2, EV_DOUBLE);
      default: ;
    endcase
    case (v.ev2)
      EV_LONG:   push_ev(k2 + L, EV_LONG);
`ifdef DOUBLE_CLICK_EN
      EV_SHORT:  push_ev(k2 + v.p2 + G, EV_SHORT);
`else
      EV_SHORT:  push_ev(k2 + v.p2, EV_SHORT);
`endif
      default: ;
    endcase
    drive(1'b1, v.p1);
    if (v.p2 > 0) begin
      drive(1'b0, v.gap);
      drive(1'b1, v.p2);
    end
    drive(1'b0, G + 10);
    drain("missing_pulse");
  endtask

  initial begin
`ifdef DOUBLE_CLICK_EN
    vecs = '{
      '{5, 0, 0, EV_SHORT, EV_NONE},
      '{5, 0, 0, EV_SHORT, EV_NONE},
      '{5, 0, 0, EV_SHORT, EV_NONE},
      '{25, 0, 0, EV_LONG, EV_NONE},
      '{5, 4, 5, EV_DOUBLE, EV_NONE},
      '{20, 0, 0, EV_SHORT, EV_NONE},
      '{21, 0, 0, EV_LONG, EV_NONE},
      '{5, 10, 5, EV_DOUBLE, EV_NONE},
      '{5, 11, 5, EV_SHORT, EV_SHORT},
      '{5, 3, 30, EV_DOUBLE, EV_NONE},
      '{25, 3, 5, EV_LONG, EV_SHORT}
    };
`else
    vecs = '{
      '{5, 0, 0, EV_SHORT, EV_NONE},
      '{5, 0, 0, EV_SHORT, EV_NONE},
      '{5, 0, 0, EV_SHORT, EV_NONE},
      '{25, 0, 0, EV_LONG, EV_NONE},
      '{5, 4, 5, EV_SHORT, EV_SHORT},
      '{20, 0, 0, EV_SHORT, EV_NONE},
      '{21, 0, 0, EV_LONG, EV_NONE},
      '{5, 10, 5, EV_SHORT, EV_SHORT},
      '{5, 11, 5, EV_SHORT, EV_SHORT},
      '{5, 3, 30, EV_SHORT, EV_LONG},
      '{25, 3, 5, EV_LONG, EV_SHORT}
    };
`endif

    // Button held through reset and beyond must be ignored.
    rst = 1'b1;
    i_switch = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pulses", int'(o_short) + int'(o_long) + int'(o_double), 0);
    chk("reset_effect", int'(o_effect), 0);
    chk("reset_bypass", int'(o_bypass), 0);
    rst = 1'b0;
    drive(1'b1, 30);
    chk("held_effect", int'(o_effect), 0);
    chk("held_bypass", int'(o_bypass), 0);
    drive(1'b0, 5);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    chk("effect_after_table", int'(o_effect), int'(model_eff));

    // Reset during the release gap aborts the pending classification.
    begin
      int r;
      r = cyc + 1 + 5;
`ifndef DOUBLE_CLICK_EN
      push_ev(r, EV_SHORT);
`endif
      drive(1'b1, 5);
      drive(1'b0, 3);
      rst = 1'b1;
      drive(1'b0, 1);
      rst = 1'b0;
      model_eff = '0;
      model_byp = 1'b0;
      drive(1'b0, G + 15);
      drain("reset_abort_queue");
      chk("reset_abort_effect", int'(o_effect), 0);
      chk("reset_abort_bypass", int'(o_bypass), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
